pc_redirect_unit: RTL and testbench
===================================

// Module: pc_redirect_unit
// PURPOSE
//  - Program-counter stage of the RV32IM pipeline. Consumes PC_SEL from bj_detect (EX stage) and the
//    ALU-computed branch/jump target.
//  - Holds the fetch PC and applies stalls and redirects. Generates flushes for the wrong-path
//    IF/ID and ID/EX contents.
//  - Parks a redirect while instruction memory is busy and applies it when the memory frees.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  CNT_WIDTH     16             width of the taken-redirect performance counter
// PORTS
//  CLK            in   1          rising-edge clock
//  RESET          in   1          asynchronous, active-high reset
//  PC_SEL         in   1          1 = branch/jump taken (from bj_detect, EX stage)
//  BJ_TARGET      in   32         redirect target address from the ALU, valid when PC_SEL=1
//  STALL          in   1          load-use stall from the hazard unit; hold PC
//  IMEM_BUSY      in   1          instruction memory not ready; hold PC
//  PC             out  32         current fetch address
//  PC_PLUS4       out  32         PC + 4 (combinational), to IF/ID for JAL/JALR link
//  FLUSH_IFID     out  1          clear IF/ID on the next edge
//  FLUSH_IDEX     out  1          clear ID/EX on the next edge
//  MISALIGNED     out  1          one-cycle pulse: the last accepted target had BJ_TARGET[1]=1
//  REDIRECT_COUNT out  CNT_WIDTH  number of accepted redirects
// BEHAVIOUR
//  Reset (asynchronous):
//    PC=RESET_VECTOR, state=RUN, PEND_TARGET=0, MISALIGNED=0, REDIRECT_COUNT=0, flushes=0.
//  States:
//    RUN      normal fetch
//    PENDING  redirect accepted while IMEM_BUSY=1; target parked in PEND_TARGET
//  RUN, evaluated per edge, in priority order:
//    1. PC_SEL=1 and IMEM_BUSY=0:
//       PC <= {BJ_TARGET[31:2],2'b00}; REDIRECT_COUNT++; stay in RUN.
//       The redirect overrides STALL, because the stalled instruction is on the wrong path.
//    2. PC_SEL=1 and IMEM_BUSY=1:
//       PEND_TARGET <= {BJ_TARGET[31:2],2'b00}; REDIRECT_COUNT++; PC holds; go to PENDING.
//    3. STALL=1 or IMEM_BUSY=1: PC holds.
//    4. Otherwise: PC <= PC+4. This is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
//  PENDING:
//    - PC_SEL is ignored. EX holds a flushed bubble, so PC_SEL is normally 0.
//    - IMEM_BUSY=1: hold.
//    - IMEM_BUSY=0: PC <= PEND_TARGET; go to RUN. STALL is ignored on this edge.
//  Flushes (combinational, same cycle):
//    - FLUSH_IDEX = (state==RUN) & PC_SEL.
//    - FLUSH_IFID = ((state==RUN) & PC_SEL) | (state==PENDING).
//    - Holding FLUSH_IFID through PENDING kills any wrong-path fetch that completes late.
//  MISALIGNED:
//    - Registered; set for exactly one cycle after an accepted redirect (paths 1 or 2) with BJ_TARGET[1]=1.
//    - BJ_TARGET[0] is silently cleared (JALR semantics) and does not raise MISALIGNED.
//  REDIRECT_COUNT: wraps from all-ones to 0.
//  Latency: a redirect is visible on PC one edge after PC_SEL=1 (path 1); no bubble beyond the two flushed slots.
//  Reset mid-PENDING: the parked target is discarded and PC returns to RESET_VECTOR.
// TESTING
//  - Reset, release, 4 idle cycles -> PC 0,4,8,12,16; flushes 0; REDIRECT_COUNT=0.
//  - At PC=0x10: PC_SEL=1, BJ_TARGET=0x100, STALL=1 in the same cycle
//    -> FLUSH_IFID=FLUSH_IDEX=1 that cycle; next PC=0x100; REDIRECT_COUNT=1.
//  - PC_SEL=1, BJ_TARGET=0x200, IMEM_BUSY=1 for 3 cycles -> PC held and FLUSH_IFID=1 each busy cycle;
//    PC=0x200 one edge after IMEM_BUSY falls; then increments to 0x204.
//  - BJ_TARGET=0x303 -> PC=0x300 and MISALIGNED pulses high for one cycle;
//    BJ_TARGET=0x301 -> PC=0x300 and MISALIGNED=0.
//  - Start at PC=0xFFFF_FFF8 -> PC=0xFFFF_FFFC, then 0x0000_0000.
//  - Assert RESET asynchronously mid-clock while in PENDING -> PC=RESET_VECTOR immediately;
//    flushes=0 and state=RUN after release.

Source files
------------

// File: rtl/pc_redirect_unit.sv
// Fetch PC register for the RV32IM pipeline: sequential fetch, stalls, taken-branch redirects,
// and a parked redirect that waits out a busy instruction memory.
module pc_redirect_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 PC_SEL,
  input  logic [31:0]          BJ_TARGET,
  input  logic                 STALL,
  input  logic                 IMEM_BUSY,
  output logic [31:0]          PC,
  output logic [31:0]          PC_PLUS4,
  output logic                 FLUSH_IFID,
  output logic                 FLUSH_IDEX,
  output logic                 MISALIGNED,
  output logic [CNT_WIDTH-1:0] REDIRECT_COUNT
);

  typedef enum logic {RUN = 1'b0, PENDING = 1'b1} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t      state;
  logic [31:0] pend_target;
  logic [31:0] tgt_aligned;
  logic        redirect_run;

  // Bit 0 is dropped silently (JALR); bit 1 is dropped but reported via MISALIGNED.
  assign tgt_aligned  = BJ_TARGET & ~32'h0000_0003;
  assign PC_PLUS4     = PC + 32'd4;
  assign redirect_run = (state == RUN) & PC_SEL;
  assign FLUSH_IDEX   = redirect_run;
  assign FLUSH_IFID   = redirect_run | (state == PENDING);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state          <= RUN;
      PC             <= RESET_VECTOR;
      pend_target    <= 32'h0;
      MISALIGNED     <= 1'b0;
      REDIRECT_COUNT <= '0;
    end else begin
      MISALIGNED <= 1'b0;
      case (state)
        RUN: begin
          if (PC_SEL) begin
            // A taken redirect wins over STALL: the stalled instruction is wrong-path.
            REDIRECT_COUNT <= REDIRECT_COUNT + CNT_ONE;
            MISALIGNED     <= BJ_TARGET[1];
            if (!IMEM_BUSY) begin
              PC <= tgt_aligned;
            end else begin
              pend_target <= tgt_aligned;
              state       <= PENDING;
            end
          end else if (!(STALL || IMEM_BUSY)) begin
            PC <= PC_PLUS4;
          end
        end
        PENDING: begin
          if (!IMEM_BUSY) begin
            PC    <= pend_target;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: a vector table walked cycle by cycle, plus an
// asynchronous reset taken while a redirect is parked.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_sel;
  logic [31:0] bj_target;
  logic        stall;
  logic        imem_busy;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush_ifid;
  logic        flush_idex;
  logic        misaligned;
  logic [15:0] redirect_count;

  int checks = 0;
  int errors = 0;

  pc_redirect_unit #(.RESET_VECTOR(32'h0000_0000), .CNT_WIDTH(16)) dut (
    .CLK(clk), .RESET(rst), .PC_SEL(pc_sel), .BJ_TARGET(bj_target), .STALL(stall),
    .IMEM_BUSY(imem_busy), .PC(pc), .PC_PLUS4(pc_plus4), .FLUSH_IFID(flush_ifid),
    .FLUSH_IDEX(flush_idex), .MISALIGNED(misaligned), .REDIRECT_COUNT(redirect_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sel;
    logic [31:0] tgt;
    logic        stl;
    logic        busy;
    logic        e_ifid;   // same-cycle flushes
    logic        e_idex;
    logic [31:0] e_pc;     // after the edge
    logic        e_mis;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(logic sel, logic [31:0] tgt, logic stl, logic busy,
                             logic fi, logic fx, logic [31:0] npc, logic mis, logic [15:0] cnt);
    vec_t r;
    r.sel = sel; r.tgt = tgt; r.stl = stl; r.busy = busy;
    r.e_ifid = fi; r.e_idex = fx; r.e_pc = npc; r.e_mis = mis; r.e_cnt = cnt;
    return r;
  endfunction

  logic [31:0] cur_pc;

  initial begin
    //        sel tgt           stl busy  ifid idex next_pc      mis cnt
    vt.push_back(v(0, 32'h0,        0, 0,   0, 0, 32'h4,        0, 0));
    vt.push_back(v(0, 32'h0,        0, 0,   0, 0, 32'h8,        0, 0));
    vt.push_back(v(0, 32'h0,        0, 0,   0, 0, 32'hC,        0, 0));
    vt.push_back(v(0, 32'h0,        0, 0,   0, 0, 32'h10,       0, 0));
    vt.push_back(v(1, 32'h100,      1, 0,   1, 1, 32'h100,      0, 1)); // redirect beats stall
    vt.push_back(v(0, 32'h0,        0, 0,   0, 0, 32'h104,      0, 1));
    vt.push_back(v(1, 32'h200,      0, 1,   1, 1, 32'h104,      0, 2)); // park
    vt.push_back(v(0, 32'h0,        0, 1,   1, 0, 32'h104,      0, 2));
    vt.push_back(v(0, 32'h0,        0, 1,   1, 0, 32'h104,      0, 2));
    vt.push_back(v(0, 32'h0,        1, 0,   1, 0, 32'h200,      0, 2)); // stall ignored on release
    vt.push_back(v(0, 32'h0,        0, 0,   0, 0, 32'h204,      0, 2));
    vt.push_back(v(1, 32'h303,      0, 0,   1, 1, 32'h300,      1, 3));
    vt.push_back(v(0, 32'h0,        0, 0,   0, 0, 32'h304,      0, 3)); // pulse is one cycle
    vt.push_back(v(1, 32'h301,      0, 0,   1, 1, 32'h300,      0, 4));
    vt.push_back(v(0, 32'h0,        1, 0,   0, 0, 32'h300,      0, 4));
    vt.push_back(v(0, 32'h0,        0, 1,   0, 0, 32'h300,      0, 4));
    vt.push_back(v(1, 32'hFFFF_FFF8,0, 0,   1, 1, 32'hFFFF_FFF8,0, 5));
    vt.push_back(v(0, 32'h0,        0, 0,   0, 0, 32'hFFFF_FFFC,0, 5));
    vt.push_back(v(0, 32'h0,        0, 0,   0, 0, 32'h0,        0, 5)); // wrap
    vt.push_back(v(1, 32'h40A,      0, 1,   1, 1, 32'h0,        1, 6)); // parked, misaligned
    vt.push_back(v(1, 32'h999,      0, 1,   1, 0, 32'h0,        0, 6)); // PC_SEL ignored in PENDING
    vt.push_back(v(0, 32'h0,        0, 0,   1, 0, 32'h408,      0, 6));
    vt.push_back(v(0, 32'h0,        0, 0,   0, 0, 32'h40C,      0, 6));

    rst = 1'b1; pc_sel = 1'b0; bj_target = 32'h0; stall = 1'b0; imem_busy = 1'b0;
    #1;
    chk("reset_pc", pc, 32'h0);
    chk("reset_cnt", 32'(redirect_count), 32'h0);
    chk("reset_mis", 32'(misaligned), 32'h0);
    chk("reset_flush", {30'h0, flush_ifid, flush_idex}, 32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    cur_pc = 32'h0;

    foreach (vt[i]) begin
      pc_sel = vt[i].sel; bj_target = vt[i].tgt; stall = vt[i].stl; imem_busy = vt[i].busy;
      #1;
      chk($sformatf("v%0d_pc", i), pc, cur_pc);
      chk($sformatf("v%0d_pc4", i), pc_plus4, cur_pc + 32'd4);
      chk($sformatf("v%0d_ifid", i), 32'(flush_ifid), 32'(vt[i].e_ifid));
      chk($sformatf("v%0d_idex", i), 32'(flush_idex), 32'(vt[i].e_idex));
      @(posedge clk); #1;
      chk($sformatf("v%0d_next_pc", i), pc, vt[i].e_pc);
      chk($sformatf("v%0d_mis", i), 32'(misaligned), 32'(vt[i].e_mis));
      chk($sformatf("v%0d_cnt", i), 32'(redirect_count), 32'(vt[i].e_cnt));
      cur_pc = vt[i].e_pc;
      @(negedge clk);
    end

    // Async reset while a redirect is parked: PC at 0x40C, park 0x500.
    pc_sel = 1'b1; bj_target = 32'h500; stall = 1'b0; imem_busy = 1'b1;
    @(posedge clk); #1;
    pc_sel = 1'b0;
    chk("park_hold", pc, 32'h40C);
    chk("park_ifid", 32'(flush_ifid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_cnt", 32'(redirect_count), 32'h0);
    @(negedge clk);
    rst = 1'b0; imem_busy = 1'b0;
    #1;
    chk("post_rst_ifid", 32'(flush_ifid), 32'h0);
    chk("post_rst_idex", 32'(flush_idex), 32'h0);
    @(posedge clk); #1;
    chk("post_rst_pc", pc, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
